convolution_procesor_accumulator: RTL
=====================================

# convolution_procesor_accumulator

Sequential, parametrised successor to the convolution processor's combinational real adder. It accumulates a run of N signed samples, such as products from the convolution multiplier, into a guard-bit accumulator. It then saturates the sum to the output width and presents it through a valid/ready output register. It sits between the product stage and the result memory writer of the convolution core.

## Interface
Parameters:
- DATA_WIDTH_IN, 16: width of each signed 2's-complement input sample.
- LEN_WIDTH, 10: width of the run-length field; at most 2^LEN_WIDTH-1 terms per run.
- ACC_WIDTH, 40: internal accumulator width; must be at least DATA_WIDTH_IN+LEN_WIDTH, so the accumulator never overflows.
- DATA_WIDTH_O, 32: output width; must be less than or equal to ACC_WIDTH.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: one-cycle request to begin a run; sampled only in IDLE or in HOLD-with-handshake.
- len, input, LEN_WIDTH: number of terms N, sampled with start.
- in_valid, input, 1: in_data is valid this cycle.
- in_data, input signed, DATA_WIDTH_IN: sample to accumulate.
- in_ready, output, 1: block accepts a sample this cycle.
- out_valid, output, 1: out_data and out_sat are valid.
- out_ready, input, 1: downstream takes the result.
- out_data, output signed, DATA_WIDTH_O: saturated sum.
- out_sat, output, 1: result was clipped.
- busy, output, 1: state is not IDLE.

## Operation
- State machine: IDLE, ACC, HOLD.
- IDLE:
  - in_ready=0, out_valid=0.
  - start with len≠0: acc←0, cnt←len, go to ACC.
  - start with len=0: out_data←0, out_sat←0, go to HOLD.
- ACC:
  - in_ready=1.
  - Acceptance: a sample is accepted when in_valid=1; acc←acc+sext(in_data), cnt←cnt−1.
  - Last sample: on acceptance with cnt=1, register sat(acc+sext(in_data)) into out_data and go to HOLD.
  - in_valid=0: no state change; bubbles are allowed indefinitely.
- HOLD:
  - out_valid=1; out_data and out_sat are stable until the handshake.
  - out_ready=1 and start=0: go to IDLE.
  - out_ready=1, start=1, len≠0: go to ACC with a new run (back-to-back).
  - out_ready=1, start=1, len=0: stay in HOLD with a zero result.
  - start without out_ready is ignored.
- start in ACC is ignored; it neither restarts nor truncates the run.
- Arithmetic:
  - Full-precision signed add in ACC_WIDTH; inputs are sign-extended.
  - Saturation at the output only: sum > 2^(DATA_WIDTH_O−1)−1 → max positive, out_sat=1; sum < −2^(DATA_WIDTH_O−1) → min negative, out_sat=1; otherwise truncate to DATA_WIDTH_O with no loss, out_sat=0.

## Timing
- Reset values: state=IDLE, acc=0, cnt=0, in_ready=0, out_valid=0, out_data=0, out_sat=0, busy=0.
- Reset mid-run: the partial sum is discarded with no output; the first post-reset edge is in IDLE.
- start→in_ready: in_ready rises one cycle after start is sampled.
- Last accept→out_valid: out_valid rises the cycle after the last accepted sample (latency 1).
- Minimum run period: N+2 cycles (start, N accepts, HOLD with out_ready=1). Back-to-back starts in HOLD save the IDLE cycle.
- in_ready and out_valid are functions of registered state only; neither depends combinationally on in_valid, out_ready or start.
- out_valid, once high, stays high with stable data until out_ready=1 (AXI-stream rule).

## Structure
- Shared package convolution_procesor_pkg:
  - typedef state_t {IDLE, ACC, HOLD}.
  - Width-check constants (ACC_WIDTH, DATA_WIDTH_IN, LEN_WIDTH) plus an elaboration assertion that ACC_WIDTH ≥ DATA_WIDTH_IN+LEN_WIDTH and DATA_WIDTH_O ≤ ACC_WIDTH.
- Sub-module convolution_procesor_satTrunc: combinational ACC_WIDTH→DATA_WIDTH_O saturating narrowing; outputs value and sat flag; reusable by other result paths.
- The FSM, counter, accumulator and output register live in the top module.

## Test plan
- Sum within range: 16-bit, N=4, inputs 100, −50, 7, 3, in_valid continuous → out_data=60, out_sat=0; out_valid one cycle after the 4th accept; in_ready high for exactly 4 cycles.
- Positive saturation: DATA_WIDTH_O=16, N=3, inputs 32767 ×3 → out_data=32767, out_sat=1. Negative saturation: inputs −32768 ×3 → out_data=−32768, out_sat=1.
- Bubbles and backpressure: N=3, in_valid pattern 1,0,0,1,0,1 with inputs 5, 6, 7; out_ready held 0 for 5 cycles → out_data=18, stable and valid all 5 cycles, IDLE one cycle after out_ready=1.
- Zero length and ignored start: start with len=0 → out_valid the next cycle, out_data=0. In a separate run, start with len=5 pulsed again at the 2nd accept → still 5 accepts, sum of those 5 only.
- Back-to-back: in HOLD, out_ready=1 and start=1 (len=2) in the same cycle → next cycle in ACC with acc=0; inputs 1, 2 → out_data=3.
- Reset mid-run: rst asserted asynchronously after 2 of 4 accepts → all outputs 0 immediately; a new run N=1 with input −9 → out_data=−9, no residue from the previous run.

Source files
------------

// File: rtl/convolution_procesor_pkg.sv
// Shared types and width defaults for the convolution processor result path.
package convolution_procesor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int unsigned DEF_DATA_WIDTH_IN = 16;
  localparam int unsigned DEF_LEN_WIDTH     = 10;
  localparam int unsigned DEF_ACC_WIDTH     = 40;
  localparam int unsigned DEF_DATA_WIDTH_O  = 32;

  // Accumulator must hold 2^len_w-1 full-scale terms; output must not be wider than it.
  function automatic bit widths_ok(input int unsigned acc_w,
                                   input int unsigned din_w,
                                   input int unsigned len_w,
                                   input int unsigned dout_w);
    return (acc_w >= din_w + len_w) && (dout_w <= acc_w);
  endfunction

endpackage

// File: rtl/convolution_procesor_satTrunc.sv
// Combinational saturating narrowing of a signed accumulator value.
module convolution_procesor_satTrunc #(
  parameter int unsigned ACC_WIDTH    = 40,
  parameter int unsigned DATA_WIDTH_O = 32
) (
  input  logic signed [ACC_WIDTH-1:0]    acc_in,
  output logic signed [DATA_WIDTH_O-1:0] value,
  output logic                           sat
);

  localparam int unsigned HEAD_W = ACC_WIDTH - DATA_WIDTH_O + 1;

  // Value fits when the dropped bits plus the new sign bit are all copies of the sign.
  logic [HEAD_W-1:0] head;
  assign head = acc_in[ACC_WIDTH-1:DATA_WIDTH_O-1];

  always_comb begin
    value = acc_in[DATA_WIDTH_O-1:0];
    sat   = 1'b0;
    if (!(&head) && (|head)) begin
      sat   = 1'b1;
      value = acc_in[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH_O-1){1'b0}}}
                                  : {1'b0, {(DATA_WIDTH_O-1){1'b1}}};
    end
  end

endmodule

// File: rtl/convolution_procesor_accumulator.sv
// Run-length accumulator: sums N signed samples, saturates, and holds the
// result in a valid/ready output register.
module convolution_procesor_accumulator
  import convolution_procesor_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_IN = DEF_DATA_WIDTH_IN,
  parameter int unsigned LEN_WIDTH     = DEF_LEN_WIDTH,
  parameter int unsigned ACC_WIDTH     = DEF_ACC_WIDTH,
  parameter int unsigned DATA_WIDTH_O  = DEF_DATA_WIDTH_O
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [LEN_WIDTH-1:0]            len,
  input  logic                            in_valid,
  input  logic signed [DATA_WIDTH_IN-1:0] in_data,
  output logic                            in_ready,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [DATA_WIDTH_O-1:0]  out_data,
  output logic                            out_sat,
  output logic                            busy
);

  if (!widths_ok(ACC_WIDTH, DATA_WIDTH_IN, LEN_WIDTH, DATA_WIDTH_O)) begin : g_width_check
    $error("convolution_procesor_accumulator: illegal width parameters");
  end

  state_t                         state;
  logic signed [ACC_WIDTH-1:0]    acc;
  logic signed [ACC_WIDTH-1:0]    acc_sum;
  logic [LEN_WIDTH-1:0]           cnt;
  logic signed [DATA_WIDTH_O-1:0] sat_value;
  logic                           sat_flag;
  logic                           take_start;

  assign acc_sum   = acc + ACC_WIDTH'(in_data);
  assign in_ready  = (state == ACC);
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);

  // start is honoured in IDLE, or in HOLD only together with the output handshake.
  assign take_start = start && ((state == IDLE) || ((state == HOLD) && out_ready));

  convolution_procesor_satTrunc #(
    .ACC_WIDTH    (ACC_WIDTH),
    .DATA_WIDTH_O (DATA_WIDTH_O)
  ) u_sat_trunc (
    .acc_in (acc_sum),
    .value  (sat_value),
    .sat    (sat_flag)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else if (take_start) begin
      if (len != '0) begin
        acc   <= '0;
        cnt   <= len;
        state <= ACC;
      end else begin
        out_data <= '0;
        out_sat  <= 1'b0;
        state    <= HOLD;
      end
    end else begin
      case (state)
        ACC: begin
          if (in_valid) begin
            acc <= acc_sum;
            cnt <= cnt - 1'b1;
            if (cnt == LEN_WIDTH'(1)) begin
              out_data <= sat_value;
              out_sat  <= sat_flag;
              state    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) state <= IDLE;
        end
        IDLE: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
